// File: rtl/runway_pattern_decoder.sv
// Recovers the wind-direction mode (w1,w0) from the runway-light pattern bus.
// Modes are confirmed over CONFIRM consistent transitions; illegal samples are counted.
module runway_pattern_decoder #(
  parameter int unsigned CONFIRM = 3,
  parameter int unsigned ERRW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [2:0]      lights,
  output logic            w1,
  output logic            w0,
  output logic            valid,
  output logic            err,
  output logic [ERRW-1:0] err_count
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  localparam logic [3:0]      CONFIRM_C = 4'(CONFIRM);
  localparam logic [ERRW-1:0] ERR_MAX   = '1;
  localparam logic [ERRW-1:0] ERR_ONE   = {{(ERRW-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [2:0]        prev_q, prev_d;
  logic [1:0]        cand_q, cand_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [ERRW-1:0]   err_count_q, err_count_d;

  logic [2:0]        cls;
  logic [3:0]        cnt_next;
  logic              bad;

  function automatic logic is_legal(input logic [2:0] p);
    case (p)
      3'b100, 3'b010, 3'b001, 3'b101: is_legal = 1'b1;
      default:                        is_legal = 1'b0;
    endcase
  endfunction

  // Returns {bad, class}; class 00 = calm, 01 = right-to-left, 10 = left-to-right.
  function automatic logic [2:0] classify(input logic [2:0] p, input logic [2:0] c);
    case ({p, c})
      6'b101_010, 6'b010_101:             classify = 3'b0_00;
      6'b100_010, 6'b010_001, 6'b001_100: classify = 3'b0_01;
      6'b001_010, 6'b010_100, 6'b100_001: classify = 3'b0_10;
      default:                            classify = 3'b1_00;
    endcase
  endfunction

  // tick is a single-cycle qualifier: lights is consumed only in a cycle with tick=1,
  // one pattern per cycle, no backpressure.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    valid_d     = valid_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    cls         = classify(prev_q, lights);
    cnt_next    = cnt_q;
    bad         = 1'b0;

    if (tick) begin
      if (!is_legal(lights)) begin
        bad     = 1'b1;
        state_d = S_EMPTY;
      end else if (state_q == S_EMPTY) begin
        prev_d  = lights;
        state_d = S_TRACK;
      end else if (cls[2]) begin
        bad     = 1'b1;
        prev_d  = lights;
        state_d = S_TRACK;
      end else begin
        prev_d = lights;
        if (cls[1:0] == cand_q) begin
          cnt_next = (cnt_q >= CONFIRM_C) ? CONFIRM_C : 4'(cnt_q + 4'd1);
        end else begin
          cand_d   = cls[1:0];
          cnt_next = 4'd1;
        end
        cnt_d = cnt_next;
        // Outputs only move once the candidate itself is confirmed (hysteresis).
        if (cnt_next == CONFIRM_C) begin
          mode_d  = cls[1:0];
          valid_d = 1'b1;
          state_d = S_LOCKED;
        end
      end

      if (bad) begin
        err_d   = 1'b1;
        valid_d = 1'b0;
        cnt_d   = 4'd0;
        if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      prev_q      <= 3'b000;
      cand_q      <= 2'b00;
      cnt_q       <= 4'd0;
      mode_q      <= 2'b00;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign w1        = mode_q[1];
  assign w0        = mode_q[0];
  assign valid     = valid_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_runway_pattern_decoder.sv
// Directed bench for runway_pattern_decoder: a CONFIRM=3 instance and a CONFIRM=1
// instance share the same stimulus; expected values are hand-derived per tick.
module tb_runway_pattern_decoder;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [2:0] lights;

  logic       w1, w0, valid, err;
  logic [7:0] err_count;
  logic       w1_1, w0_1, valid_1, err_1;
  logic [7:0] err_count_1;

  int n_cmp = 0;
  int n_bad = 0;

  runway_pattern_decoder #(.CONFIRM(3), .ERRW(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .lights    (lights),
    .w1        (w1),
    .w0        (w0),
    .valid     (valid),
    .err       (err),
    .err_count (err_count)
  );

  runway_pattern_decoder #(.CONFIRM(1), .ERRW(8)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .lights    (lights),
    .w1        (w1_1),
    .w0        (w0_1),
    .valid     (valid_1),
    .err       (err_1),
    .err_count (err_count_1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Checks w1w0, valid, err, err_count of the CONFIRM=3 instance.
  task automatic expect3(input string tag, input logic [1:0] w, input logic v,
                         input logic e, input logic [7:0] ec);
    check({tag, ".w"},   {30'd0, w1, w0}, {30'd0, w});
    check({tag, ".v"},   {31'd0, valid},  {31'd0, v});
    check({tag, ".err"}, {31'd0, err},    {31'd0, e});
    check({tag, ".ec"},  {24'd0, err_count}, {24'd0, ec});
  endtask

  task automatic expect1(input string tag, input logic [1:0] w, input logic v);
    check({tag, ".w1"}, {30'd0, w1_1, w0_1}, {30'd0, w});
    check({tag, ".v1"}, {31'd0, valid_1},    {31'd0, v});
  endtask

  // driver tasks: returns #1 after the edge that consumed the tick
  task automatic do_tick(input logic [2:0] p);
    @(negedge clk);
    tick   = 1'b1;
    lights = p;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [2:0] illegal_pat [4];

  initial begin
    illegal_pat[0] = 3'b000;
    illegal_pat[1] = 3'b011;
    illegal_pat[2] = 3'b110;
    illegal_pat[3] = 3'b111;
    reset  = 1'b1;
    tick   = 1'b0;
    lights = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    expect3("rst", 2'b00, 1'b0, 1'b0, 8'd0);
    expect1("rst", 2'b00, 1'b0);

    // calm confirmation
    do_tick(3'b101); expect3("calm_t1", 2'b00, 1'b0, 1'b0, 8'd0); expect1("calm_t1", 2'b00, 1'b0);
    do_tick(3'b010); expect3("calm_t2", 2'b00, 1'b0, 1'b0, 8'd0); expect1("calm_t2", 2'b00, 1'b1);
    do_tick(3'b101); expect3("calm_t3", 2'b00, 1'b0, 1'b0, 8'd0);
    do_tick(3'b010); expect3("calm_t4", 2'b00, 1'b1, 1'b0, 8'd0);

    // right-to-left confirmation; first transition 010->100 is LR
    do_tick(3'b100); expect3("rl_t1", 2'b00, 1'b1, 1'b0, 8'd0); expect1("rl_t1", 2'b10, 1'b1);
    do_tick(3'b010); expect3("rl_t2", 2'b00, 1'b1, 1'b0, 8'd0); expect1("rl_t2", 2'b01, 1'b1);
    do_tick(3'b001); expect3("rl_t3", 2'b00, 1'b1, 1'b0, 8'd0);
    do_tick(3'b100); expect3("rl_t4", 2'b01, 1'b1, 1'b0, 8'd0);

    // left-to-right confirmation, then two saturating LR transitions
    do_tick(3'b001); expect3("lr_t1", 2'b01, 1'b1, 1'b0, 8'd0); expect1("lr_t1", 2'b10, 1'b1);
    do_tick(3'b010); expect3("lr_t2", 2'b01, 1'b1, 1'b0, 8'd0);
    do_tick(3'b100); expect3("lr_t3", 2'b10, 1'b1, 1'b0, 8'd0);
    do_tick(3'b001); expect3("lr_t4", 2'b10, 1'b1, 1'b0, 8'd0);
    do_tick(3'b010); expect3("lr_t5", 2'b10, 1'b1, 1'b0, 8'd0);

    // hysteresis: LR held until calm reaches CONFIRM
    do_tick(3'b101); expect3("hys_t1", 2'b10, 1'b1, 1'b0, 8'd0); expect1("hys_t1", 2'b00, 1'b1);
    do_tick(3'b010); expect3("hys_t2", 2'b10, 1'b1, 1'b0, 8'd0);
    do_tick(3'b101); expect3("hys_t3", 2'b00, 1'b1, 1'b0, 8'd0);

    // illegal pattern while locked
    do_tick(3'b111); expect3("ill", 2'b00, 1'b0, 1'b1, 8'd1); expect1("ill", 2'b00, 1'b0);
    idle_cycle();    expect3("ill_idle", 2'b00, 1'b0, 1'b0, 8'd1);
    do_tick(3'b101); expect3("rec_t1", 2'b00, 1'b0, 1'b0, 8'd1);
    do_tick(3'b010); expect3("rec_t2", 2'b00, 1'b0, 1'b0, 8'd1);
    do_tick(3'b101); expect3("rec_t3", 2'b00, 1'b0, 1'b0, 8'd1);
    do_tick(3'b010); expect3("rec_t4", 2'b00, 1'b1, 1'b0, 8'd1);

    // repeated pattern is a BAD transition
    do_tick(3'b010); expect3("rep_1", 2'b00, 1'b0, 1'b1, 8'd2);
    do_tick(3'b010); expect3("rep_2", 2'b00, 1'b0, 1'b1, 8'd3);

    // saturation of the error counter with back-to-back illegal ticks
    for (int i = 0; i < 300; i++) begin
      do_tick(illegal_pat[i % 4]);
      if (i == 99)  expect3("sat_100", 2'b00, 1'b0, 1'b1, 8'd103);
      if (i == 251) expect3("sat_252", 2'b00, 1'b0, 1'b1, 8'd255);
    end
    expect3("sat_300", 2'b00, 1'b0, 1'b1, 8'd255);
    check("sat_300.ec1", {24'd0, err_count_1}, 32'd255);
    idle_cycle(); expect3("sat_idle", 2'b00, 1'b0, 1'b0, 8'd255);

    // reset and tick in the same cycle: tick discarded
    @(negedge clk);
    reset  = 1'b1;
    tick   = 1'b1;
    lights = 3'b100;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick  = 1'b0;
    expect3("rst_tick", 2'b00, 1'b0, 1'b0, 8'd0);
    expect1("rst_tick", 2'b00, 1'b0);
    do_tick(3'b100); expect3("post_rst_t1", 2'b00, 1'b0, 1'b0, 8'd0); expect1("post_rst_t1", 2'b00, 1'b0);
    do_tick(3'b010); expect3("post_rst_t2", 2'b00, 1'b0, 1'b0, 8'd0); expect1("post_rst_t2", 2'b01, 1'b1);

    // reset mid-confirmation restarts from EMPTY with cnt cleared
    do_reset();      expect3("mid_rst", 2'b00, 1'b0, 1'b0, 8'd0); expect1("mid_rst", 2'b00, 1'b0);
    do_tick(3'b001); expect3("mid_t1", 2'b00, 1'b0, 1'b0, 8'd0); expect1("mid_t1", 2'b00, 1'b0);
    do_tick(3'b100); expect3("mid_t2", 2'b00, 1'b0, 1'b0, 8'd0);
    do_tick(3'b010); expect3("mid_t3", 2'b00, 1'b0, 1'b0, 8'd0);
    do_tick(3'b001); expect3("mid_t4", 2'b01, 1'b1, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
